dot_product_sequencer: RTL
==========================

// Module: dot_product_sequencer
// PURPOSE
//  Sequences the DotProduct datapath over NUM_ROWS weight rows for one feature vector.
//  Streams one weight-row read per cycle, tracks DotProduct pipeline latency with a tag pipe,
//  and emits each row score. Keeps a running signed argmax and reports class/score on done.
//  Sits between the top-level classifier control and the weight ROM + DotProduct pair.
// PARAMETERS
//  NUM_ROWS  10  weight rows (classes) per run; 2..16
//  ROW_AW    4   row address / class index width; 2**ROW_AW >= NUM_ROWS
//  PIPE_LAT  4   DotProduct latency, cycles from B_* valid to value valid; >= 1
//  RES_W     26  DotProduct result width (signed two's complement, 8.18 fixed point)
// PORTS
//  clk          in   1      system clock, rising edge
//  GlobalReset  in   1      asynchronous, active-high reset
//  start        in   1      request a run; sampled only in IDLE
//  busy         out  1      high from the cycle after start is accepted until done
//  done         out  1      one-cycle pulse; best_class/best_value valid in that cycle
//  row_rd_en    out  1      weight ROM read strobe
//  row_addr     out  ROW_AW weight ROM row address; ROM data reaches B_* 1 cycle later
//  dp_value     in   RES_W  DotProduct value output
//  score_valid  out  1      one-cycle pulse per captured row score
//  score_idx    out  ROW_AW row index of score_value
//  score_value  out  RES_W  captured dp_value
//  best_class   out  ROW_AW argmax row index; held until next accepted start
//  best_value   out  RES_W  maximum score; held until next accepted start
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, row_rd_en, score_valid = 0; row_addr, score_idx,
//    best_class = 0; score_value = 0; best_value = most-negative RES_W value; tag pipe cleared.
//  - FSM: IDLE -> ISSUE on start; ISSUE -> DRAIN after issuing row NUM_ROWS-1;
//    DRAIN -> DONE when tag pipe empty; DONE -> IDLE unconditionally (1 cycle, done=1).
//  - Accepting start clears best_value to most-negative and best_class to 0.
//  - ISSUE: row_rd_en=1, row_addr=0,1,..,NUM_ROWS-1 on consecutive cycles, no gaps.
//  - Tag pipe: depth 1+PIPE_LAT, entry = {valid, row index}; pushed each ISSUE cycle.
//    Entry exiting the pipe samples dp_value: score_valid=1, score_idx=tag, score_value=dp_value
//    (registered, visible the cycle after the sampling edge).
//  - Argmax: signed compare, update only when dp_value > best_value (strict); ties keep the
//    lower index. Updated on the same edge score_value is registered.
//  - Latency: done is high exactly NUM_ROWS+PIPE_LAT+2 cycles after the edge that samples
//    start (16 with defaults); final score_valid pulse occurs the cycle before done.
//  - start while busy or in DONE: ignored, no queuing. start held high: a new run begins
//    from IDLE the cycle after done.
//  - GlobalReset mid-run: all state cleared asynchronously; no done pulse; partial best lost.
//  - Outside ISSUE, row_rd_en=0 and row_addr holds its last value.
// STRUCTURE
//  - Shared package: FSM state enum (IDLE, ISSUE, DRAIN, DONE), RES_W, ROW_AW,
//    RES_MIN constant (most-negative score), tag struct {valid, idx}.
//  - One sub-module: dp_tag_pipe (parameterised depth shift register of tags, clear on reset).
//  - FSM, row counter, score capture and argmax stay in this module.
// TESTING
//  Bench uses a behavioural DotProduct model with delay PIPE_LAT and a scripted ROM.
//  - Scores 0,2,4,..,18 (A=2.0, B=i) -> score_idx 0..9 in order, best_class=9,
//    best_value=18.0, done 16 cycles after start edge.
//  - Scores all -1.0 except row 3 = -0.5 -> best_class=3, best_value=-0.5 (signed compare).
//  - Rows 2 and 7 both = 5.0 max -> best_class=2 (tie keeps lower index).
//  - start re-pulsed during ISSUE and DRAIN -> ignored; exactly one done, 10 score_valid pulses.
//  - GlobalReset asserted mid-DRAIN -> immediate IDLE, busy=0, no done; next start gives
//    a clean run with correct argmax.
//  - start held high across two runs -> back-to-back runs, second start accepted the cycle
//    after done, best_* reset between runs.

Source files
------------

// File: rtl/dot_product_sequencer_pkg.sv
// Shared types and constants for the dot-product row sequencer.
// Scores are signed 8.18 fixed point; RES_MIN seeds the running argmax.
package dot_product_sequencer_pkg;
  localparam int RES_W  = 26;
  localparam int ROW_AW = 4;

  localparam logic signed [RES_W-1:0] RES_MIN = {1'b1, {(RES_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [ROW_AW-1:0] idx;
  } tag_t;
endpackage

// File: rtl/dot_product_sequencer_if.sv
// Control, weight-ROM and DotProduct-side signals of the row sequencer.
// master = classifier control / bench side, slave = sequencer side.
interface dot_product_sequencer_if;
  import dot_product_sequencer_pkg::*;

  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     row_rd_en;
  logic [ROW_AW-1:0]        row_addr;
  logic signed [RES_W-1:0]  dp_value;
  logic                     score_valid;
  logic [ROW_AW-1:0]        score_idx;
  logic signed [RES_W-1:0]  score_value;
  logic [ROW_AW-1:0]        best_class;
  logic signed [RES_W-1:0]  best_value;

  modport master (
    output start, dp_value,
    input  busy, done, row_rd_en, row_addr, score_valid, score_idx, score_value,
           best_class, best_value
  );

  modport slave (
    input  start, dp_value,
    output busy, done, row_rd_en, row_addr, score_valid, score_idx, score_value,
           best_class, best_value
  );
endinterface

// File: rtl/dot_product_sequencer_dp_tag_pipe.sv
// Shift register of row tags that mirrors the ROM + DotProduct latency.
// The last stage is the tag whose score is on dp_value this cycle.
module dp_tag_pipe
  import dot_product_sequencer_pkg::*;
#(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic rst,
  input  tag_t push_i,
  output tag_t pop_o,
  output logic busy_o
);

  tag_t pipe_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= push_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy_o = busy_o | pipe_q[i].valid;
  end

  assign pop_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/dot_product_sequencer.sv
// Issues one weight-row read per cycle, captures each DotProduct score as it
// leaves the pipeline, and tracks a signed running argmax over the rows.
module dot_product_sequencer
  import dot_product_sequencer_pkg::*;
#(
  parameter int NUM_ROWS = 10,
  parameter int PIPE_LAT = 4
) (
  input  logic                     clk,
  input  logic                     GlobalReset,
  dot_product_sequencer_if.slave   bus
);

  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(NUM_ROWS - 1);

  state_e                  state_q, state_d;
  logic [ROW_AW-1:0]       row_q, row_d;
  logic                    clear_best;
  logic                    score_valid_q;
  logic [ROW_AW-1:0]       score_idx_q;
  logic signed [RES_W-1:0] score_value_q;
  logic [ROW_AW-1:0]       best_class_q;
  logic signed [RES_W-1:0] best_value_q;
  tag_t                    push_tag, pop_tag;
  logic                    pipe_busy;

  // One extra stage covers the ROM read cycle ahead of the DotProduct latency.
  dp_tag_pipe #(.DEPTH(1 + PIPE_LAT)) u_tag_pipe (
    .clk    (clk),
    .rst    (GlobalReset),
    .push_i (push_tag),
    .pop_o  (pop_tag),
    .busy_o (pipe_busy)
  );

  assign push_tag.valid = (state_q == ST_ISSUE);
  assign push_tag.idx   = row_q;

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    clear_best = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_ISSUE;
          row_d      = '0;
          clear_best = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (row_q == LAST_ROW) state_d = ST_DRAIN;
        else                   row_d   = row_q + 1'b1;
      end
      ST_DRAIN: begin
        if (!pipe_busy) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strict compare: on a tie the earlier (lower) row index is kept.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      score_valid_q <= 1'b0;
      score_idx_q   <= '0;
      score_value_q <= '0;
      best_class_q  <= '0;
      best_value_q  <= RES_MIN;
    end else begin
      score_valid_q <= pop_tag.valid;
      if (pop_tag.valid) begin
        score_idx_q   <= pop_tag.idx;
        score_value_q <= bus.dp_value;
      end
      if (clear_best) begin
        best_class_q <= '0;
        best_value_q <= RES_MIN;
      end else if (pop_tag.valid && (bus.dp_value > best_value_q)) begin
        best_class_q <= pop_tag.idx;
        best_value_q <= bus.dp_value;
      end
    end
  end

  assign bus.busy        = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.row_rd_en   = (state_q == ST_ISSUE);
  assign bus.row_addr    = row_q;
  assign bus.score_valid = score_valid_q;
  assign bus.score_idx   = score_idx_q;
  assign bus.score_value = score_value_q;
  assign bus.best_class  = best_class_q;
  assign bus.best_value  = best_value_q;

endmodule
